// File: rtl/bin2bcd_pipe_if.sv
// Handshake bundle for bin2bcd_pipe: operand side (in_*), result side (out_*/bcd/ovf/sign)
// and the busy status. The master drives operands and result acceptance; the slave is the
// converter.
interface bin2bcd_pipe_if #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;
  logic                  sign_out;
  logic                  busy;

  modport master (
    output in_valid,
    output bin_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  bcd_out,
    input  ovf,
    input  sign_out,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  bin_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output bcd_out,
    output ovf,
    output sign_out,
    output busy
  );
endinterface

// File: rtl/bin2bcd_pipe.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per cycle) with
// valid/ready handshakes on both sides and saturation to all 9s on overflow.
// Optional feature macro: BIN2BCD_SIGNED_EN -- treat bin_in as two's complement, convert
// its magnitude and report the sign on sign_out. Undefined: unsigned input, sign_out = 0.
module bin2bcd_pipe #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  bin2bcd_pipe_if.slave   bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [BCD_W-1:0] NINES    = {DIGITS{4'h9}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [BIN_W-1:0] r_shift;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] r_bcd_out;
  logic             r_ovf;
  logic             r_sign;
  logic             r_in_ready;

  logic [1:0]       w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic [BCD_W-1:0] w_bcd_adj;
  logic [BCD_W-1:0] w_bcd_shl;
  logic             w_ovf_nxt;
  logic [BIN_W-1:0] w_mag;
  logic             w_sign;

`ifdef BIN2BCD_SIGNED_EN
  // Magnitude as BIN_W-bit unsigned, so the most-negative value maps to 2^(BIN_W-1).
  assign w_sign = bus.bin_in[BIN_W-1];
  assign w_mag  = w_sign ? (~bus.bin_in + BIN_W'(1)) : bus.bin_in;
`else
  assign w_sign = 1'b0;
  assign w_mag  = bus.bin_in;
`endif

  assign w_accept = (r_state == ST_IDLE) && r_in_ready && bus.in_valid;
  assign w_last   = (r_cnt == CNT_LAST);

  // Add-3 correction on every digit in parallel; a digit <= 9 never carries out.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  // Shift the next operand bit in; a bit falling out of the top digit means overflow.
  assign w_bcd_shl = {w_bcd_adj[BCD_W-2:0], r_shift[BIN_W-1]};
  assign w_ovf_nxt = r_ovf | w_bcd_adj[BCD_W-1];

  // Next-state decode for IDLE -> CONV -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)       w_state_nxt = ST_CONV;
      ST_CONV: if (w_last)         w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready)  w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and output registers; reset clears everything including in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_bcd_out  <= '0;
      r_ovf      <= 1'b0;
      r_sign     <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // Registered so in_ready stays low through reset and rises only in IDLE.
      r_in_ready <= (w_state_nxt == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift   <= w_mag;
            r_bcd     <= '0;
            r_bcd_out <= '0;
            r_ovf     <= 1'b0;
            r_sign    <= w_sign;
            r_cnt     <= '0;
          end
        end
        ST_CONV: begin
          r_bcd   <= w_bcd_shl;
          r_shift <= r_shift << 1;
          r_ovf   <= w_ovf_nxt;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_bcd_out <= w_ovf_nxt ? NINES : w_bcd_shl;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state == ST_CONV);
  assign bus.bcd_out   = r_bcd_out;
  assign bus.ovf       = r_ovf;
  assign bus.sign_out  = r_sign;

endmodule

// File: tb/tb_bin2bcd_pipe.sv
// Directed bench for bin2bcd_pipe: a 3-digit and a 2-digit instance see the same 8-bit
// stimulus, so overflow/saturation is exercised alongside the full-range conversion.
module tb_bin2bcd_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] bin_in;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [11:0] res3;
  logic [7:0]  res2;
  logic        ovf3, ovf2, sgn3;
  int          lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_pipe_if #(.BIN_W(8), .DIGITS(3)) b3 ();
  bin2bcd_pipe_if #(.BIN_W(8), .DIGITS(2)) b2 ();

  assign b3.in_valid  = in_valid;
  assign b3.bin_in    = bin_in;
  assign b3.out_ready = out_ready;
  assign b2.in_valid  = in_valid;
  assign b2.bin_in    = bin_in;
  assign b2.out_ready = out_ready;

  bin2bcd_pipe #(.BIN_W(8), .DIGITS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
  bin2bcd_pipe #(.BIN_W(8), .DIGITS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!b3.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("in_ready", 32'(b3.in_ready), 32'd1);
  endtask

  // One conversion: hold out_ready low for 'hold' cycles after out_valid, then accept.
  task automatic convert(input logic [7:0] v, input int hold);
    int          n;
    int          unstable;
    logic [11:0] first;
    wait_ready();
    bin_in   = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bin_in   = ~v;  // must not be sampled while converting
    check_eq("busy", 32'(b3.busy), 32'd1);
    n = 0;
    while (!b3.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("out_valid", 32'(b3.out_valid), 32'd1);
    lat      = n;
    first    = b3.bcd_out;
    unstable = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!b3.out_valid || b3.bcd_out !== first || b3.in_ready) unstable++;
    end
    check_eq("hold_stable", 32'(unstable), 32'd0);
    res3 = b3.bcd_out;
    ovf3 = b3.ovf;
    sgn3 = b3.sign_out;
    res2 = b2.bcd_out;
    ovf2 = b2.ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("ov_drop", 32'(b3.out_valid), 32'd0);
    check_eq("rdy_back", 32'(b3.in_ready), 32'd1);
  endtask

  initial begin
    int          t0, t1, n;
    logic [11:0] r0, r1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin_in    = '0;
    rst_n     = 1'b0;
    #3;
    check_eq("rst_in_ready", 32'(b3.in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(b3.out_valid), 32'd0);
    check_eq("rst_bcd", 32'(b3.bcd_out), 32'd0);
    check_eq("rst_ovf", 32'(b3.ovf), 32'd0);
    check_eq("rst_busy", 32'(b3.busy), 32'd0);
    check_eq("rst_sign", 32'(b3.sign_out), 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-scale value; DONE is entered on the 8th edge after the accept edge.
    convert(8'd255, 0);
    check_eq("255_bcd3", 32'(res3), 32'h255);
    check_eq("255_ovf3", 32'(ovf3), 32'd0);
    check_eq("255_lat", 32'(lat), 32'd8);
    check_eq("255_bcd2", 32'(res2), 32'h99);
    check_eq("255_ovf2", 32'(ovf2), 32'd1);

    // Back-pressure for 20 cycles.
    convert(8'd137, 20);
    check_eq("137_bcd3", 32'(res3), 32'h137);

    convert(8'd200, 0);
    check_eq("200_bcd3", 32'(res3), 32'h200);
    check_eq("200_bcd2", 32'(res2), 32'h99);
    check_eq("200_ovf2", 32'(ovf2), 32'd1);

    convert(8'd99, 0);
    check_eq("99_bcd3", 32'(res3), 32'h099);
    check_eq("99_bcd2", 32'(res2), 32'h99);
    check_eq("99_ovf2", 32'(ovf2), 32'd0);

    // Back-to-back with in_valid held high and out_ready held high.
    wait_ready();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    bin_in    = 8'd0;
    @(posedge clk); #1;
    t0     = cyc;
    bin_in = 8'd99;
    n = 0;
    while (!b3.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    r0 = b3.bcd_out;
    n = 0;
    while (!b3.in_ready && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    t1       = cyc;
    in_valid = 1'b0;
    n = 0;
    while (!b3.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    r1 = b3.bcd_out;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("b2b_first", 32'(r0), 32'h000);
    check_eq("b2b_second", 32'(r1), 32'h099);
    check_eq("b2b_period", 32'(t1 - t0), 32'd10);

    // Reset in the 4th CONV cycle: outputs clear without a clock edge.
    wait_ready();
    bin_in   = 8'd255;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(b3.busy), 32'd0);
    check_eq("mid_rst_valid", 32'(b3.out_valid), 32'd0);
    check_eq("mid_rst_bcd", 32'(b3.bcd_out), 32'd0);
    check_eq("mid_rst_ready", 32'(b3.in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    convert(8'd42, 0);
    check_eq("42_bcd3", 32'(res3), 32'h042);

    convert(8'h80, 0);
`ifdef BIN2BCD_SIGNED_EN
    check_eq("80_bcd3", 32'(res3), 32'h128);
    check_eq("80_sign", 32'(sgn3), 32'd1);
`else
    check_eq("80_bcd3", 32'(res3), 32'h128);
    check_eq("80_sign", 32'(sgn3), 32'd0);
`endif
    convert(8'hFF, 0);
`ifdef BIN2BCD_SIGNED_EN
    check_eq("ff_bcd3", 32'(res3), 32'h001);
    check_eq("ff_sign", 32'(sgn3), 32'd1);
`else
    check_eq("ff_bcd3", 32'(res3), 32'h255);
    check_eq("ff_sign", 32'(sgn3), 32'd0);
`endif
    convert(8'h7F, 0);
    check_eq("7f_bcd3", 32'(res3), 32'h127);
    check_eq("7f_sign", 32'(sgn3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
